// File: rtl/serial_add_unit_if.sv
// serial_add_unit_if: handshake and operand/result bundle for the bit-serial adder
interface serial_add_unit_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y;
    logic             carry;

    modport master (
        output en, start, A, B, cin,
        input  busy, done, Y, carry
    );

    modport slave (
        input  en, start, A, B, cin,
        output busy, done, Y, carry
    );
endinterface

// File: rtl/serial_add_unit.sv
// serial_add_unit: LSB-first bit-serial adder, one full-adder cell plus a carry flip-flop
module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    serial_add_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_y;
    logic [CW-1:0]    r_cnt;
    logic             r_cff;
    logic             r_busy;
    logic             r_done;
    logic             r_carry;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res;

    assign w_s   = r_op_a[0] ^ r_op_b[0] ^ r_cff;
    assign w_c   = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_cff) | (r_op_b[0] & r_cff);
    assign w_res = {w_s, r_res[WIDTH-1:1]};

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.Y     = r_y;
    assign bus.carry = r_carry;

    // Control FSM and datapath: capture on start, one sum bit per enabled edge, publish on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_res   <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
            r_cff   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_carry <= 1'b0;
        end else if (bus.en) begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.start) begin
                    r_op_a  <= bus.A;
                    r_op_b  <= bus.B;
                    r_cff   <= bus.cin;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= SHIFT;
                end
            end else begin
                r_cff  <= w_c;
                r_res  <= w_res;
                r_op_a <= r_op_a >> 1;
                r_op_b <= r_op_b >> 1;
                r_cnt  <= r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_y     <= w_res;
                    r_carry <= w_c;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_add_unit.sv
// tb_serial_add_unit: directed and randomized checks of serial_add_unit against A+B+cin
module tb_serial_add_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_add_unit_if #(.WIDTH(8)) bus ();

    serial_add_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One addition: start it, optionally stall and re-assert start, then check latency and result
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input int st_after, input int st_n, input logic [15:0] restart);
        logic [8:0] exp_sum;
        logic [7:0] y_hold;
        logic       c_hold;
        int         lat;
        exp_sum = 9'(a) + 9'(b) + 9'(ci);
        bus.A = a;
        bus.B = b;
        bus.cin = ci;
        bus.en = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_on", 32'(bus.busy), 32'd1);
        check("done_clr", 32'(bus.done), 32'd0);
        y_hold = bus.Y;
        c_hold = bus.carry;
        bus.A = 8'($urandom);
        bus.B = 8'($urandom);
        bus.cin = 1'($urandom);
        lat = 0;
        while (lat < 40) begin
            lat++;
            bus.en = !(lat > st_after && lat <= st_after + st_n);
            bus.start = (lat < 16) ? restart[lat] : 1'b0;
            if (bus.start) begin
                bus.A = 8'($urandom);
                bus.B = 8'($urandom);
            end
            step();
            bus.start = 1'b0;
            if (bus.done) break;
            check("busy_mid", 32'(bus.busy), 32'd1);
            check("y_hold", {23'd0, bus.carry, bus.Y}, {23'd0, c_hold, y_hold});
        end
        bus.en = 1'b1;
        check("latency", 32'(lat), 32'(8 + st_n));
        check("busy_off", 32'(bus.busy), 32'd0);
        check("sum", {23'd0, bus.carry, bus.Y}, {23'd0, exp_sum});
    endtask

    initial begin
        int any_done;
        int st_after;
        int st_n;
        bus.en = 1'b1;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.cin = 1'b0;
        #1;
        check("rst_out", {21'd0, bus.busy, bus.done, bus.carry, bus.Y}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_out", {21'd0, bus.busy, bus.done, bus.carry, bus.Y}, 32'd0);

        op(8'h00, 8'h00, 1'b0, 100, 0, 16'h0000);
        bus.en = 1'b0;
        step();
        check("done_stretch", 32'(bus.done), 32'd1);
        bus.en = 1'b1;
        step();
        check("done_1cyc", 32'(bus.done), 32'd0);

        op(8'hFF, 8'h01, 1'b0, 100, 0, 16'h0000);
        step();
        check("done_1cyc_wrap", 32'(bus.done), 32'd0);

        op(8'h5A, 8'h3C, 1'b1, 100, 0, 16'h0000);
        op(8'h5A, 8'h3C, 1'b1, 4, 3, 16'h0000);
        op(8'h01, 8'h01, 1'b0, 100, 0, 16'h0104);
        op(8'h33, 8'h44, 1'b0, 100, 0, 16'h0000);

        bus.A = 8'hF0;
        bus.B = 8'h0F;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {21'd0, bus.busy, bus.done, bus.carry, bus.Y}, 32'd0);
        step();
        rst_n = 1'b1;
        any_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            any_done |= int'(bus.done) | int'(bus.busy);
        end
        check("no_done_after_rst", 32'(any_done), 32'd0);
        op(8'h0F, 8'hF0, 1'b1, 100, 0, 16'h0000);

        for (int i = 0; i < 40; i++) begin
            st_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            st_after = int'($urandom_range(1, 7));
            op(8'($urandom), 8'($urandom), 1'($urandom), st_after, st_n, 16'($urandom) & 16'h01FE);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_add_unit.md
Name: serial_add_unit

Overview:
- Bit-serial, LSB-first adder. It is the inverse (restoring) operation of the team's half-subtractor datapath: it rebuilds a minuend from a difference and a subtrahend.
- Adds two WIDTH-bit operands plus carry-in over WIDTH clock cycles, using a single full-adder cell and a carry flip-flop.
- Start/busy/done handshake with the shared gating enable `en`.
- Sits beside the subtractor blocks as the low-area arithmetic unit that the stimulus and checker logic uses.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  global enable; 0 freezes all state (stall)
- start  input  1  request; sampled only in IDLE with en=1
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle completion pulse
- Y  output  WIDTH  sum result, registered
- carry  output  1  carry-out (bit WIDTH of A+B+cin), registered

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE.
  - busy=0, done=0, Y=0, carry=0.
  - Internal shift registers, carry FF and bit counter cleared.
  - Takes effect immediately, including mid-operation; the in-flight operation is discarded with no done pulse.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with en=1 and start=1, capture A, B, cin into opA/opB/cff and clear the counter.
  - Then busy=1 and next state is SHIFT.
  - done is cleared on any en=1 edge where no completion occurs.
- SHIFT, each edge with en=1:
  - s = opA[0]^opB[0]^cff.
  - cff <= majority(opA[0], opB[0], cff).
  - Shift s into the MSB of an internal result register.
  - opA and opB shift right by one bit.
  - cnt++.
- Completion:
  - On the edge that processes bit WIDTH-1, load Y <= final result register (including that bit) and carry <= the new carry value.
  - On the same edge: done <= 1, busy <= 0, state <= IDLE.
- Latency: start accepted at edge E0; done, Y and carry are valid after edge E_WIDTH (8 enabled edges later for WIDTH=8).
- done is high for exactly one enabled cycle. The next en=1 edge clears it.
- Y and carry hold their values until the next completion or reset. They never show partial sums.
- en=0:
  - Every register holds, including done, so a done pulse stretches across the stall.
  - start is ignored.
  - The bit position resumes unchanged when en returns to 1.
- start while busy=1: ignored, and operands are not re-sampled.
- start on the same edge as a completion: ignored, because state is still SHIFT. A new start is accepted on the following edge.
- Arithmetic:
  - {carry,Y} == A + B + cin, computed modulo 2^(WIDTH+1).
  - Wrap-around at all-ones is reported only via carry.
- Inputs A, B and cin may change freely after acceptance without affecting the result.

Test Plan:
- Reset, then WIDTH=8, A=8'h00, B=8'h00, cin=0, start pulse -> done exactly 8 edges later; Y=8'h00, carry=0; busy high for those 8 cycles.
- A=8'hFF, B=8'h01, cin=0 -> Y=8'h00, carry=1 (wrap-around); done pulse 1 cycle wide.
- A=8'h5A, B=8'h3C, cin=1 -> Y=8'h97, carry=0. Change A and B to 8'hAA the cycle after start -> result unchanged.
- Repeat 8'h5A+8'h3C+1 with en=0 for 3 cycles after bit 3 -> done delayed to 11 edges after start; Y=8'h97; all outputs frozen during the stall.
- Assert start again at cycles 2 and 8 of an operation (8'h01+8'h01) -> both ignored; single done with Y=8'h02. A start on the cycle after done is accepted.
- Drive rst_n=0 asynchronously mid-operation (cycle 4 of 8'hF0+8'h0F) -> busy, done, Y and carry go to 0 immediately and no done pulse follows. A fresh 8'h0F+8'hF0+1 then gives Y=8'h00, carry=1.
